// File: rtl/axi_default_slave.sv
// AXI default slave: answers every request that reaches it with DECERR, reads and writes handled independently.
// Optional define DEFSLV_ERR_LOG_EN adds err_cnt / err_addr error logging outputs.
module axi_default_slave #(
    parameter int unsigned ID_W   = 8,
    parameter int unsigned DATA_W = 32
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    input  logic [ID_W-1:0]     AWID,
    input  logic [31:0]         AWADDR,
    input  logic [3:0]          AWLEN,
    input  logic [2:0]          AWSIZE,
    input  logic [1:0]          AWBURST,
    input  logic                AWVALID,
    output logic                AWREADY,
    input  logic [DATA_W-1:0]   WDATA,
    input  logic [DATA_W/8-1:0] WSTRB,
    input  logic                WLAST,
    input  logic                WVALID,
    output logic                WREADY,
    output logic [ID_W-1:0]     BID,
    output logic [1:0]          BRESP,
    output logic                BVALID,
    input  logic                BREADY,
    input  logic [ID_W-1:0]     ARID,
    input  logic [31:0]         ARADDR,
    input  logic [3:0]          ARLEN,
    input  logic [2:0]          ARSIZE,
    input  logic [1:0]          ARBURST,
    input  logic                ARVALID,
    output logic                ARREADY,
    output logic [ID_W-1:0]     RID,
    output logic [DATA_W-1:0]   RDATA,
    output logic [1:0]          RRESP,
    output logic                RLAST,
    output logic                RVALID,
    input  logic                RREADY
`ifdef DEFSLV_ERR_LOG_EN
    ,
    output logic [15:0]         err_cnt,
    output logic [31:0]         err_addr
`endif
);

    localparam int unsigned STRB_W      = DATA_W / 8;
    localparam logic [1:0]  RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    w_state_t    w_state;
    r_state_t    r_state;
    logic [3:0]  beat_cnt;
    logic        aw_hs;
    logic        ar_hs;

    assign aw_hs = AWVALID && AWREADY;
    assign ar_hs = ARVALID && ARREADY;

    // Write channel: take the address, swallow beats until WLAST, then hold B until accepted.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            w_state <= W_IDLE;
            AWREADY <= 1'b0;
            WREADY  <= 1'b0;
            BVALID  <= 1'b0;
            BRESP   <= 2'b00;
            BID     <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (aw_hs) begin
                        BID     <= AWID;
                        AWREADY <= 1'b0;
                        WREADY  <= 1'b1;
                        w_state <= W_DATA;
                    end else begin
                        AWREADY <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (WVALID && WREADY && WLAST) begin
                        WREADY  <= 1'b0;
                        BVALID  <= 1'b1;
                        BRESP   <= RESP_DECERR;
                        w_state <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (BVALID && BREADY) begin
                        BVALID  <= 1'b0;
                        BRESP   <= 2'b00;
                        AWREADY <= 1'b1;
                        w_state <= W_IDLE;
                    end
                end
                default: begin
                    w_state <= W_IDLE;
                    AWREADY <= 1'b0;
                    WREADY  <= 1'b0;
                    BVALID  <= 1'b0;
                end
            endcase
        end
    end

    // Read channel: ARLEN+1 zero-data DECERR beats; the counter holds the beats still owed after the current one.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            r_state  <= R_IDLE;
            ARREADY  <= 1'b0;
            RVALID   <= 1'b0;
            RLAST    <= 1'b0;
            RRESP    <= 2'b00;
            RID      <= '0;
            RDATA    <= '0;
            beat_cnt <= 4'd0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ar_hs) begin
                        RID      <= ARID;
                        beat_cnt <= ARLEN;
                        ARREADY  <= 1'b0;
                        RVALID   <= 1'b1;
                        RRESP    <= RESP_DECERR;
                        RLAST    <= (ARLEN == 4'd0);
                        r_state  <= R_DATA;
                    end else begin
                        ARREADY <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (RVALID && RREADY) begin
                        if (beat_cnt != 4'd0) begin
                            beat_cnt <= beat_cnt - 4'd1;
                            RLAST    <= (beat_cnt == 4'd1);
                        end else begin
                            RVALID  <= 1'b0;
                            RLAST   <= 1'b0;
                            RRESP   <= 2'b00;
                            ARREADY <= 1'b1;
                            r_state <= R_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= R_IDLE;
                    ARREADY <= 1'b0;
                    RVALID  <= 1'b0;
                    RLAST   <= 1'b0;
                end
            endcase
        end
    end

`ifdef DEFSLV_ERR_LOG_EN
    logic [16:0] cnt_sum;

    assign cnt_sum = {1'b0, err_cnt} + 17'(ar_hs) + 17'(aw_hs);

    // Saturating count of accepted requests; a read address takes priority over a same-cycle write address.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            err_cnt  <= 16'd0;
            err_addr <= 32'd0;
        end else begin
            err_cnt <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
            if (ar_hs) begin
                err_addr <= ARADDR;
            end else if (aw_hs) begin
                err_addr <= AWADDR;
            end
        end
    end

    logic unused_inputs;
    assign unused_inputs = ^{AWLEN, AWSIZE, AWBURST, ARSIZE, ARBURST, WDATA, WSTRB[STRB_W-1:0]};
`else
    logic unused_inputs;
    assign unused_inputs = ^{AWADDR, ARADDR, AWLEN, AWSIZE, AWBURST, ARSIZE, ARBURST,
                             WDATA, WSTRB[STRB_W-1:0]};
`endif

endmodule

// File: doc/axi_default_slave.md
AXI_DEFAULT_SLAVE -- requirements
Module: axi_default_slave

Interface
REQ-001 SHALL have parameter ID_W, default 8, slave-side ID width (master ID plus master index).
REQ-002 SHALL have parameter DATA_W, default 32, data width; STRB width is DATA_W/8.
REQ-003 SHALL have port ACLK, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port ARESETn, input, 1, reset that is synchronous and active-low.
REQ-005 SHALL have AW ports: AWID in ID_W; AWADDR in 32; AWLEN in 4; AWSIZE in 3; AWBURST in 2; AWVALID in 1; AWREADY out 1.
REQ-006 SHALL have W ports: WDATA in DATA_W; WSTRB in DATA_W/8; WLAST in 1; WVALID in 1; WREADY out 1.
REQ-007 SHALL have B ports: BID out ID_W; BRESP out 2; BVALID out 1; BREADY in 1.
REQ-008 SHALL have AR ports: ARID in ID_W; ARADDR in 32; ARLEN in 4; ARSIZE in 3; ARBURST in 2; ARVALID in 1; ARREADY out 1.
REQ-009 SHALL have R ports: RID out ID_W; RDATA out DATA_W; RRESP out 2; RLAST out 1; RVALID out 1; RREADY in 1.

Function
REQ-010 SHALL act as the AXI responder for every unmapped address; every response is DECERR (2'b11).
REQ-011 SHALL implement independent read and write FSMs; simultaneous AR and AW handshakes are both accepted in the same cycle.
REQ-012 Write FSM SHALL have states W_IDLE, W_DATA, W_RESP; all outputs are registered.
REQ-013 W_IDLE: AWREADY=1 and WREADY=0; on AWVALID&AWREADY, capture AWID and go to W_DATA; AWREADY=0 from the next cycle.
REQ-014 W_DATA: WREADY=1; every beat is accepted and discarded; on WVALID&WREADY&WLAST, go to W_RESP; WREADY=0 from the next cycle.
REQ-015 WLAST alone SHALL terminate the write; a beat count different from AWLEN+1 is tolerated without error.
REQ-016 W_RESP: BVALID=1, BID=captured ID, BRESP=2'b11; these hold stable until BREADY; on BVALID&BREADY, go to W_IDLE with AWREADY=1 in the next cycle.
REQ-017 Read FSM SHALL have states R_IDLE and R_DATA, with a 4-bit beat counter.
REQ-018 R_IDLE: ARREADY=1; on ARVALID&ARREADY, capture ARID, load counter with ARLEN, and go to R_DATA; ARREADY=0 from the next cycle.
REQ-019 R_DATA: RVALID=1, RDATA=0, RRESP=2'b11, RID=captured ID, RLAST=1 exactly when counter==0.
REQ-020 On RVALID&RREADY with counter!=0, SHALL decrement the counter; with counter==0, SHALL go to R_IDLE; ARLEN=15 yields exactly 16 beats.
REQ-021 R outputs SHALL hold stable while RVALID=1 and RREADY=0; back-to-back beats are allowed with RREADY held high (one beat per cycle).
REQ-022 Minimum latency SHALL be: AR handshake to first RVALID = 1 cycle; WLAST handshake to BVALID = 1 cycle.
REQ-023 AWADDR, AWSIZE, AWBURST, ARSIZE, ARBURST, WDATA and WSTRB SHALL be ignored.

Reset
REQ-024 While ARESETn=0 at a rising edge, SHALL go to W_IDLE/R_IDLE, clear the counter and IDs, and drive all outputs to 0.
REQ-025 On the first edge with ARESETn=1, SHALL set AWREADY=1 and ARREADY=1.
REQ-026 Reset asserted mid-burst or mid-response SHALL abort the transaction with no further beats or response.

Configuration
REQ-027 Macro DEFSLV_ERR_LOG_EN, when defined, SHALL add outputs err_cnt (16-bit) and err_addr (32-bit).
REQ-028 With the macro: err_cnt increments by 1 per accepted AR or AW, by 2 when both occur in one cycle, and saturates at 16'hFFFF; err_addr captures the address of the last accepted request (ARADDR wins on a tie); both reset to 0.
REQ-029 Without the macro: these ports and registers SHALL be absent; all other behaviour is identical.

Verification
REQ-030 ARID=8'h13, ARLEN=3, RREADY=1 -> 4 consecutive beats, RID=8'h13, RDATA=0, RRESP=2'b11, RLAST only on beat 4, ARREADY=1 the cycle after.
REQ-031 AWID=8'h21, 2 W beats (WLAST on the 2nd), BREADY low for 3 cycles -> BVALID held for 3 cycles with BID=8'h21, BRESP=2'b11, completes when BREADY=1.
REQ-032 AR and AW handshakes in the same cycle, ARLEN=0 -> one R beat with RLAST=1 and one B response, each DECERR, in parallel.
REQ-033 ARLEN=15, RREADY toggled every cycle -> exactly 16 beats, R outputs stable during stalls.
REQ-034 ARESETn low during beat 2 of an ARLEN=7 burst -> RVALID=0 on the next edge, ARREADY=1 on the first edge after release.
REQ-035 With DEFSLV_ERR_LOG_EN: 3 reads plus 2 writes with the last ARADDR=32'h2000_0040 -> err_cnt=5, err_addr=32'h2000_0040.
